ram256_arbiter: RTL and testbench

//  Shares one RAM256 (single-port, 256 x WSIZE*8, synchronous read) between two requesters, A and B.

---
 rtl/ram256_arbiter_if.sv | 26 ++
 rtl/ram256_arbiter.sv | 140 ++++++++++++++
 tb/tb_ram256_arbiter.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ram256_arbiter_if.sv
// Purpose: one requester's access bus into the RAM256 arbiter.
// Latency: gnt is combinational with req; rvalid/rdata follow a read grant by one cycle.
// Backpressure: the requester holds req and its payload stable until gnt is seen high.
interface ram256_arbiter_if #(
   parameter int WSIZE = 4
);
   logic                 req;
   logic [WSIZE-1:0]     we;
   logic [7:0]           addr;
   logic [WSIZE*8-1:0]   wdata;
   logic                 gnt;
   logic                 rvalid;
   logic [WSIZE*8-1:0]   rdata;

   // Requester side (CPU bus bridge, DMA).
   modport master (
      output req, we, addr, wdata,
      input  gnt, rvalid, rdata
   );

   // Arbiter side.
   modport slave (
      input  req, we, addr, wdata,
      output gnt, rvalid, rdata
   );
endinterface

// File: rtl/ram256_arbiter.sv
// Purpose: round-robin sharing of one RAM256 between requesters A and B, plus a full-array clear sequencer.
// Latency: grant and RAM strobe in the request cycle; read data and rvalid one cycle after the grant.
// Backpressure: a losing or blocked (CLEAR) request stays pending until granted; CLEAR runs 256 cycles.
module ram256_arbiter #(
   parameter int WSIZE          = 4,
   parameter bit CLEAR_ON_RESET = 1'b0
) (
   input  logic                 CLK,
   input  logic                 resetb,
   input  logic                 clr_start,
   output logic                 clr_busy,
   ram256_arbiter_if.slave      port_a,
   ram256_arbiter_if.slave      port_b,
   output logic                 ram_en,
   output logic [WSIZE-1:0]     ram_we,
   output logic [7:0]           ram_a,
   output logic [WSIZE*8-1:0]   ram_di,
   input  logic [WSIZE*8-1:0]   ram_do
);

   localparam logic [0:0] ST_ARB   = 1'b0;
   localparam logic [0:0] ST_CLEAR = 1'b1;
   localparam logic [0:0] ST_RESET = CLEAR_ON_RESET ? ST_CLEAR : ST_ARB;

   logic [0:0] state;
   logic [7:0] clr_cnt;
   logic       last_b;
   logic       rvalid_a_q;
   logic       rvalid_b_q;

   logic       in_arb;
   logic       in_clear;
   logic       gnt_a;
   logic       gnt_b;
   logic       rd_a;
   logic       rd_b;
   logic       clr_last;

   // gnt/ram_en are qualified with resetb so nothing reaches the RAM while reset is held,
   // even when the reset state is CLEAR.
   assign in_arb   = resetb && (state == ST_ARB);
   assign in_clear = resetb && (state == ST_CLEAR);
   assign clr_last = (clr_cnt == 8'hFF);

   // Round-robin: on a tie, the port that did not win last time gets the slot.
   always_comb begin
      gnt_a = 1'b0;
      gnt_b = 1'b0;
      if (in_arb) begin
         if (port_a.req && port_b.req) begin
            gnt_a = last_b;
            gnt_b = !last_b;
         end else begin
            gnt_a = port_a.req;
            gnt_b = port_b.req;
         end
      end
   end

   assign rd_a = gnt_a && (port_a.we == '0);
   assign rd_b = gnt_b && (port_b.we == '0);

   // RAM strobe mux: clear sequencer, then granted requester, else idle.
   always_comb begin
      ram_en = 1'b0;
      ram_we = '0;
      ram_a  = 8'h00;
      ram_di = '0;
      if (in_clear) begin
         ram_en = 1'b1;
         ram_we = '1;
         ram_a  = clr_cnt;
         ram_di = '0;
      end else if (gnt_a) begin
         ram_en = 1'b1;
         ram_we = port_a.we;
         ram_a  = port_a.addr;
         ram_di = port_a.wdata;
      end else if (gnt_b) begin
         ram_en = 1'b1;
         ram_we = port_b.we;
         ram_a  = port_b.addr;
         ram_di = port_b.wdata;
      end
   end

   // Mode FSM: clr_start is only honoured in ARB; CLEAR exits after address 255 is written.
   always_ff @(posedge CLK or negedge resetb) begin
      if (!resetb) begin
         state <= ST_RESET;
      end else begin
         case (state)
            ST_ARB:   if (clr_start) state <= ST_CLEAR;
            ST_CLEAR: if (clr_last)  state <= ST_ARB;
            default:  state <= ST_ARB;
         endcase
      end
   end

   // Clear address counter; the 8-bit wrap returns it to 0 on the way back to ARB.
   always_ff @(posedge CLK or negedge resetb) begin
      if (!resetb) begin
         clr_cnt <= 8'h00;
      end else if (state == ST_CLEAR) begin
         clr_cnt <= clr_cnt + 8'h01;
      end
   end

   // Remember who won last; reset to B so that A takes the first tie.
   always_ff @(posedge CLK or negedge resetb) begin
      if (!resetb) begin
         last_b <= 1'b1;
      end else if (gnt_a) begin
         last_b <= 1'b0;
      end else if (gnt_b) begin
         last_b <= 1'b1;
      end
   end

   // Read strobes line up with the RAM's registered output one cycle after the grant.
   always_ff @(posedge CLK or negedge resetb) begin
      if (!resetb) begin
         rvalid_a_q <= 1'b0;
         rvalid_b_q <= 1'b0;
      end else begin
         rvalid_a_q <= rd_a;
         rvalid_b_q <= rd_b;
      end
   end

   assign clr_busy      = (state == ST_CLEAR);
   assign port_a.gnt    = gnt_a;
   assign port_b.gnt    = gnt_b;
   assign port_a.rvalid = rvalid_a_q;
   assign port_b.rvalid = rvalid_b_q;
   // Both read buses see the RAM output directly; the rvalid strobes say whose data it is.
   assign port_a.rdata  = ram_do;
   assign port_b.rdata  = ram_do;

endmodule

// File: tb/tb_ram256_arbiter.sv
// Purpose: directed bench for ram256_arbiter with a behavioural RAM256 model.
// Latency: inputs driven at the falling edge, outputs sampled 1 time unit later.
// Backpressure: requests are held until their grant is observed.
module tb_ram256_arbiter;

   localparam int WSIZE = 4;

   logic CLK = 1'b0;
   always #5 CLK = ~CLK;

   logic        resetb;
   logic        rst2;
   logic        clr_start;
   logic        clr_busy;
   logic        clr_busy2;
   logic        ram_en,  ram_en2;
   logic [3:0]  ram_we,  ram_we2;
   logic [7:0]  ram_a,   ram_a2;
   logic [31:0] ram_di,  ram_di2;
   logic [31:0] ram_do;
   logic [31:0] ram_do2;
   logic        mem_init;
   logic [31:0] mem [256];

   int vectors     = 0;
   int miscompares = 0;
   int overlap     = 0;

   ram256_arbiter_if #(.WSIZE(WSIZE)) pa ();
   ram256_arbiter_if #(.WSIZE(WSIZE)) pb ();
   ram256_arbiter_if #(.WSIZE(WSIZE)) pa2 ();
   ram256_arbiter_if #(.WSIZE(WSIZE)) pb2 ();

   ram256_arbiter #(.WSIZE(WSIZE), .CLEAR_ON_RESET(1'b0)) dut (
      .CLK(CLK), .resetb(resetb), .clr_start(clr_start), .clr_busy(clr_busy),
      .port_a(pa), .port_b(pb),
      .ram_en(ram_en), .ram_we(ram_we), .ram_a(ram_a), .ram_di(ram_di), .ram_do(ram_do)
   );

   ram256_arbiter #(.WSIZE(WSIZE), .CLEAR_ON_RESET(1'b1)) dut2 (
      .CLK(CLK), .resetb(rst2), .clr_start(1'b0), .clr_busy(clr_busy2),
      .port_a(pa2), .port_b(pb2),
      .ram_en(ram_en2), .ram_we(ram_we2), .ram_a(ram_a2), .ram_di(ram_di2), .ram_do(ram_do2)
   );

   assign ram_do2 = 32'h0;

   function automatic logic [31:0] pat(input logic [7:0] a);
      return {8'h5A, 8'hC3, ~a, a};
   endfunction

   // RAM256 model: byte-masked write, registered read of the pre-write contents.
   always @(posedge CLK) begin
      if (mem_init) begin
         for (int i = 0; i < 256; i++) mem[i] <= pat(8'(i));
      end else if (ram_en) begin
         for (int j = 0; j < 4; j++)
            if (ram_we[j]) mem[ram_a][8*j +: 8] <= ram_di[8*j +: 8];
         ram_do <= mem[ram_a];
      end
   end

   // Mutual exclusion of grants, watched on every cycle.
   always begin
      @(negedge CLK);
      #2;
      if (pa.gnt && pb.gnt) overlap++;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   // One single-port access; checks the grant, then rvalid/rdata one cycle later.
   task automatic access(input bit on_b, input logic [3:0] we, input logic [7:0] addr,
                         input logic [31:0] wd, input logic [31:0] exp, input string tag);
      @(negedge CLK);
      if (on_b) begin
         pb.req = 1'b1; pb.we = we; pb.addr = addr; pb.wdata = wd;
      end else begin
         pa.req = 1'b1; pa.we = we; pa.addr = addr; pa.wdata = wd;
      end
      #1;
      chk({tag, "/gnt"}, 32'(on_b ? pb.gnt : pa.gnt), 32'd1);
      @(negedge CLK);
      pa.req = 1'b0;
      pb.req = 1'b0;
      #1;
      chk({tag, "/rvalid"}, 32'(on_b ? pb.rvalid : pa.rvalid), 32'(we == 4'd0));
      if (we == 4'd0) chk({tag, "/rdata"}, on_b ? pb.rdata : pa.rdata, exp);
   endtask

   initial begin
      int busy;
      int gnt_in_clr;
      int seq_err;
      bit found;

      resetb = 1'b0; rst2 = 1'b0; clr_start = 1'b0; mem_init = 1'b1;
      pa.req = 1'b1; pa.we = 4'h0; pa.addr = 8'h00; pa.wdata = 32'h0;
      pb.req = 1'b0; pb.we = 4'h0; pb.addr = 8'h00; pb.wdata = 32'h0;
      pa2.req = 1'b0; pa2.we = 4'h0; pa2.addr = 8'h00; pa2.wdata = 32'h0;
      pb2.req = 1'b0; pb2.we = 4'h0; pb2.addr = 8'h00; pb2.wdata = 32'h0;

      // Reset state: request held but nothing may be granted.
      repeat (2) @(negedge CLK);
      #1;
      chk("rst/gnt_a",    32'(pa.gnt),    32'd0);
      chk("rst/ram_en",   32'(ram_en),    32'd0);
      chk("rst/rvalid_a", 32'(pa.rvalid), 32'd0);
      chk("rst/rvalid_b", 32'(pb.rvalid), 32'd0);
      chk("rst/clr_busy", 32'(clr_busy),  32'd0);
      chk("rst/busy2",    32'(clr_busy2), 32'd1);
      chk("rst/ram_en2",  32'(ram_en2),   32'd0);
      @(negedge CLK);
      mem_init = 1'b0; pa.req = 1'b0; resetb = 1'b1;
      #1;
      chk("rel/clr_busy", 32'(clr_busy), 32'd0);
      chk("rel/ram_en",   32'(ram_en),   32'd0);

      // Full write then read on A.
      access(1'b0, 4'hF, 8'h10, 32'hDEADBEEF, 32'h0,        "t1w");
      access(1'b0, 4'h0, 8'h10, 32'h0,        32'hDEADBEEF, "t1r");

      // Byte-lane write on B.
      access(1'b1, 4'hF,    8'h40, 32'h11223344, 32'h0,        "t3w");
      access(1'b1, 4'b0100, 8'h40, 32'h00AA0000, 32'h0,        "t3b");
      access(1'b1, 4'h0,    8'h40, 32'h0,        32'h11AA3344, "t3r");

      // Contention: last winner was B, so A leads A,B,A,B,A,B.
      @(negedge CLK);
      pa.req = 1'b1; pa.we = 4'h0; pa.addr = 8'h20;
      pb.req = 1'b1; pb.we = 4'h0; pb.addr = 8'h21;
      for (int k = 0; k < 6; k++) begin
         #1;
         chk($sformatf("t2/gnt_a%0d", k), 32'(pa.gnt), 32'(k % 2 == 0));
         chk($sformatf("t2/gnt_b%0d", k), 32'(pb.gnt), 32'(k % 2 == 1));
         if (k > 0) begin
            chk($sformatf("t2/rv_a%0d", k), 32'(pa.rvalid), 32'(k % 2 == 1));
            chk($sformatf("t2/rv_b%0d", k), 32'(pb.rvalid), 32'(k % 2 == 0));
            chk($sformatf("t2/rd%0d", k), ram_do, (k % 2 == 1) ? pat(8'h20) : pat(8'h21));
         end
         @(negedge CLK);
      end
      pa.req = 1'b0; pb.req = 1'b0;
      #1;
      chk("t2/rv_b_last", 32'(pb.rvalid), 32'd1);
      chk("t2/rd_last",   pb.rdata,       pat(8'h21));

      // Reset in the middle of a clear at address 100.
      @(negedge CLK);
      clr_start = 1'b1;
      @(negedge CLK);
      clr_start = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 300; i++) begin
         #1;
         if (clr_busy && ram_a == 8'd100) begin
            found = 1'b1;
            break;
         end
         @(negedge CLK);
      end
      chk("t6/reach100", 32'(found), 32'd1);
      pa.req = 1'b1; pa.we = 4'h0; pa.addr = 8'd99;
      resetb = 1'b0;
      #1;
      chk("t6/gnt_a",    32'(pa.gnt),    32'd0);
      chk("t6/ram_en",   32'(ram_en),    32'd0);
      chk("t6/rvalid_a", 32'(pa.rvalid), 32'd0);
      chk("t6/clr_busy", 32'(clr_busy),  32'd0);
      @(negedge CLK);
      resetb = 1'b1;
      #1;
      chk("t6/arb",      32'(clr_busy), 32'd0);
      chk("t6/gnt_rel",  32'(pa.gnt),   32'd1);
      @(negedge CLK);
      pa.req = 1'b0;
      #1;
      chk("t6/rv99", 32'(pa.rvalid), 32'd1);
      chk("t6/rd99", pa.rdata,       32'h0);
      access(1'b0, 4'h0, 8'd100, 32'h0, pat(8'd100), "t6r100");
      access(1'b0, 4'h0, 8'd200, 32'h0, pat(8'd200), "t6r200");

      // Full clear with A held pending; a read granted with clr_start still completes.
      access(1'b0, 4'hF, 8'h00, 32'h11111111, 32'h0, "t4f0");
      access(1'b0, 4'hF, 8'h80, 32'h22222222, 32'h0, "t4f1");
      access(1'b0, 4'hF, 8'hFF, 32'h33333333, 32'h0, "t4f2");
      @(negedge CLK);
      clr_start = 1'b1;
      pa.req = 1'b1; pa.we = 4'h0; pa.addr = 8'h80;
      #1;
      chk("t4/gnt_start", 32'(pa.gnt), 32'd1);
      @(negedge CLK);
      clr_start = 1'b0;
      pa.addr = 8'h00;
      #1;
      chk("t4/rv_in_clr", 32'(pa.rvalid), 32'd1);
      chk("t4/rd_in_clr", pa.rdata,       32'h22222222);
      busy = 0; gnt_in_clr = 0; seq_err = 0;
      for (int i = 0; i < 300; i++) begin
         if (!clr_busy) break;
         if (pa.gnt) gnt_in_clr++;
         if (ram_a != 8'(busy) || ram_we != 4'hF || ram_di != 32'h0 || !ram_en) seq_err++;
         busy++;
         @(negedge CLK);
         #1;
      end
      chk("t4/busy_cycles", 32'(busy),       32'd256);
      chk("t4/gnt_in_clr",  32'(gnt_in_clr), 32'd0);
      chk("t4/seq_err",     32'(seq_err),    32'd0);
      chk("t4/gnt_after",   32'(pa.gnt),     32'd1);
      @(negedge CLK);
      pa.req = 1'b0;
      #1;
      chk("t4/rv00", 32'(pa.rvalid), 32'd1);
      chk("t4/rd00", pa.rdata,       32'h0);
      access(1'b0, 4'h0, 8'h80, 32'h0, 32'h0, "t4r80");
      access(1'b1, 4'h0, 8'hFF, 32'h0, 32'h0, "t4rFF");

      // Clear-on-reset instance.
      @(negedge CLK);
      rst2 = 1'b1;
      #1;
      chk("t5/busy0", 32'(clr_busy2), 32'd1);
      busy = 0; seq_err = 0;
      for (int i = 0; i < 300; i++) begin
         if (!clr_busy2) break;
         if (ram_a2 != 8'(busy) || ram_we2 != 4'hF || !ram_en2) seq_err++;
         busy++;
         @(negedge CLK);
         #1;
      end
      chk("t5/busy_cycles", 32'(busy),    32'd256);
      chk("t5/seq_err",     32'(seq_err), 32'd0);
      chk("t5/ram_en_arb",  32'(ram_en2), 32'd0);

      chk("gnt_overlap", 32'(overlap), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
